// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through channels 0..3, settles dwell+1 cycles each, samples Y into a 4-bit result
// Ports: clk, rst (async, active-high); start, abort, dwell[DWELL_W-1:0] in;
//        sel[1:0] to mux S; mux_y from mux Y; busy, done, result[3:0] out.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  input  logic               mux_y,
  output logic               busy,
  output logic               done,
  output logic [3:0]         result
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_q, dwell_n;
  logic [3:0] work, work_n, result_n;
  logic [1:0] sel_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      work    <= '0;
      result  <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      dwell_q <= dwell_n;
      work    <= work_n;
      result  <= result_n;
    end
  end
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    cnt_n    = cnt;
    dwell_n  = dwell_q;
    work_n   = work;
    result_n = result;
    case (state)
      IDLE: begin
        sel_n = '0;
        if (start) begin
          dwell_n = dwell;
          cnt_n   = '0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n = IDLE;
          sel_n   = '0;
        end else if (cnt != dwell_q) begin
          cnt_n = cnt + 1'b1;
        end else begin
          work_n[sel] = mux_y;
          cnt_n       = '0;
          if (sel == 2'd3) begin
            result_n = {mux_y, work[2:0]};
            state_n  = DONE;
          end else begin
            sel_n = sel + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        sel_n   = '0;
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase
  end
  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and random scans checked against an elapsed-cycle reference model
module tb_mux_scan_ctrl;
  logic clk = 0, rst = 0, start = 0, abort = 0;
  logic [3:0] dwell = 0, iv = 0;
  logic [1:0] sel;
  logic mux_y, busy, done;
  logic [3:0] result;
  int checks = 0, errors = 0;
  bit act = 0;
  int n = 0, d = 0;
  logic [3:0] bits = 0, res = 0;

  mux_scan_ctrl #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell(dwell),
    .sel(sel), .mux_y(mux_y), .busy(busy), .done(done), .result(result)
  );

  assign mux_y = iv[sel];
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_done();
    return act && n == 4 * (d + 1);
  endfunction

  function automatic logic [1:0] m_sel();
    return !act ? 2'd0 : m_done() ? 2'd3 : 2'(n / (d + 1));
  endfunction

  task automatic step(logic s, logic a, logic [3:0] dw, logic [3:0] i);
    chk("sel", 4'(sel), 4'(m_sel()));
    chk("busy", 4'(busy), 4'(act));
    chk("done", 4'(done), 4'(m_done()));
    chk("result", result, res);
    start = s; abort = a; dwell = dw; iv = i;
    @(posedge clk);
    if (!act) begin
      if (s) begin act = 1; n = 0; d = int'(dw); end
    end else if (m_done()) act = 0;
    else if (a) act = 0;
    else begin
      int k = n / (d + 1);
      if ((n + 1) % (d + 1) == 0) bits[k] = i[k];
      n++;
      if (n == 4 * (d + 1)) res = bits;
    end
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 rst = 1;
    #1;
    chk("rst_sel", 4'(sel), 4'd0);
    chk("rst_busy", 4'(busy), 4'd0);
    chk("rst_done", 4'(done), 4'd0);
    chk("rst_result", result, 4'd0);
    act = 0; res = 0; bits = 0; start = 0; abort = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    @(negedge clk);
    reset_mid();
    step(1, 0, 0, 4'b1010);
    repeat (6) step(0, 0, 0, 4'b1010);
    step(1, 0, 3, 4'b0110);
    repeat (8) step(0, 0, 3, 4'b0110);
    repeat (12) step(0, 0, 7, 4'b0110);
    step(1, 0, 0, 4'b1111);
    repeat (5) step(0, 0, 0, 4'b1111);
    step(1, 0, 2, 4'b0000);
    step(0, 0, 2, 4'b0000);
    step(1, 0, 2, 4'b0000);
    for (int t = 0; t < 20 && m_sel() != 2; t++) step(0, 0, 2, 4'b0000);
    chk("abort_at_sel2", 4'(m_sel()), 4'd2);
    step(0, 1, 2, 4'b0000);
    repeat (3) step(0, 0, 2, 4'b0000);
    step(1, 0, 1, 4'b1001);
    for (int t = 0; t < 20 && m_sel() != 1; t++) step(0, 0, 1, 4'b1001);
    chk("rst_at_sel1", 4'(m_sel()), 4'd1);
    reset_mid();
    step(1, 0, 1, 4'b1001);
    repeat (10) step(0, 0, 1, 4'b1001);
    step(1, 0, 1, 4'b0011);
    repeat (8) step(0, 0, 1, 4'b0011);
    step(1, 0, 1, 4'b0011);
    step(1, 0, 1, 4'b1100);
    repeat (10) step(0, 0, 1, 4'b1100);
    for (int r = 0; r < 3; r++) begin
      repeat (300) step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                        4'($urandom), 4'($urandom));
      reset_mid();
    end
    step(0, 0, 0, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
